// File: rtl/traffic_pkg.sv
// Shared phase codes, light patterns and light-field bit positions for the
// sensor-actuated two-road traffic-light controller.
package traffic_pkg;

    localparam logic [2:0] PH_MAIN_G  = 3'd0;
    localparam logic [2:0] PH_MAIN_Y  = 3'd1;
    localparam logic [2:0] PH_ALLR_MS = 3'd2;
    localparam logic [2:0] PH_SIDE_G  = 3'd3;
    localparam logic [2:0] PH_SIDE_Y  = 3'd4;
    localparam logic [2:0] PH_ALLR_SM = 3'd5;

    localparam int unsigned LB_MAIN_R = 5;
    localparam int unsigned LB_MAIN_Y = 4;
    localparam int unsigned LB_MAIN_G = 3;
    localparam int unsigned LB_SIDE_R = 2;
    localparam int unsigned LB_SIDE_Y = 1;
    localparam int unsigned LB_SIDE_G = 0;

    localparam logic [5:0] LT_MAIN_G  = (6'b000001 << LB_MAIN_G) | (6'b000001 << LB_SIDE_R);
    localparam logic [5:0] LT_MAIN_Y  = (6'b000001 << LB_MAIN_Y) | (6'b000001 << LB_SIDE_R);
    localparam logic [5:0] LT_ALLR    = (6'b000001 << LB_MAIN_R) | (6'b000001 << LB_SIDE_R);
    localparam logic [5:0] LT_SIDE_G  = (6'b000001 << LB_MAIN_R) | (6'b000001 << LB_SIDE_G);
    localparam logic [5:0] LT_SIDE_Y  = (6'b000001 << LB_MAIN_R) | (6'b000001 << LB_SIDE_Y);

    // Unknown codes show all-red so a corrupted state never lights a green.
    function automatic logic [5:0] phase_lights(input logic [2:0] ph);
        logic [5:0] lt;
        case (ph)
            PH_MAIN_G:  lt = LT_MAIN_G;
            PH_MAIN_Y:  lt = LT_MAIN_Y;
            PH_ALLR_MS: lt = LT_ALLR;
            PH_SIDE_G:  lt = LT_SIDE_G;
            PH_SIDE_Y:  lt = LT_SIDE_Y;
            PH_ALLR_SM: lt = LT_ALLR;
            default:    lt = LT_ALLR;
        endcase
        return lt;
    endfunction

endpackage

// File: rtl/traffic_ctrl_act_phase_timer.sv
// Phase timer: clears on state entry, counts up, saturates at a selectable
// limit and presents the threshold flags the controller needs.
module phase_timer #(
    parameter int CNT_W      = 5,
    parameter int T_MAIN_MIN = 10,
    parameter int T_SIDE_MIN = 5,
    parameter int T_SIDE_MAX = 15,
    parameter int T_YEL      = 3,
    parameter int T_ALLRED   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             sat_main_i,
    output logic             main_min_o,
    output logic             side_min_o,
    output logic             side_max_o,
    output logic             yel_done_o,
    output logic             allred_done_o
);

    localparam logic [CNT_W-1:0] LIM_MAIN = CNT_W'(T_MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] LIM_SMIN = CNT_W'(T_SIDE_MIN - 1);
    localparam logic [CNT_W-1:0] LIM_SMAX = CNT_W'(T_SIDE_MAX - 1);
    localparam logic [CNT_W-1:0] LIM_YEL  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] LIM_ALLR = CNT_W'(T_ALLRED - 1);

    logic [CNT_W-1:0] tmr_q;
    logic [CNT_W-1:0] tmr_d;
    logic [CNT_W-1:0] sat_s;

    // Next count: clear wins, otherwise increment up to the active ceiling.
    always_comb begin
        tmr_d = tmr_q;
        sat_s = sat_main_i ? LIM_MAIN : {CNT_W{1'b1}};
        if (clr_i) begin
            tmr_d = '0;
        end else if (tmr_q >= sat_s) begin
            tmr_d = tmr_q;
        end else begin
            tmr_d = tmr_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign main_min_o    = (tmr_q >= LIM_MAIN);
    assign side_min_o    = (tmr_q >= LIM_SMIN);
    assign side_max_o    = (tmr_q == LIM_SMAX);
    assign yel_done_o    = (tmr_q == LIM_YEL);
    assign allred_done_o = (tmr_q == LIM_ALLR);

endmodule

// File: rtl/traffic_ctrl_act.sv
// Sensor-actuated two-road traffic-light controller with registered outputs.
// Optional pedestrian request/walk feature enabled by macro TRAFFIC_PED_EN.
module traffic_ctrl_act
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int T_MAIN_MIN = 10,
    parameter int T_SIDE_MIN = 5,
    parameter int T_SIDE_MAX = 15,
    parameter int T_YEL      = 3,
    parameter int T_ALLRED   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       traffic,
`ifdef TRAFFIC_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [5:0] light,
    output logic [2:0] phase
);

    localparam longint TMAX = longint'(1) << CNT_W;

    if (T_MAIN_MIN < 1 || T_SIDE_MIN < 1 || T_SIDE_MAX < 1 || T_YEL < 1 || T_ALLRED < 1 ||
        T_SIDE_MIN > T_SIDE_MAX ||
        T_MAIN_MIN > TMAX || T_SIDE_MIN > TMAX || T_SIDE_MAX > TMAX ||
        T_YEL > TMAX || T_ALLRED > TMAX) begin : g_bad_params
        $error("traffic_ctrl_act: illegal timing parameters");
    end

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [5:0] light_q;
    logic       req_s;
    logic       main_min_s;
    logic       side_min_s;
    logic       side_max_s;
    logic       yel_done_s;
    logic       allred_done_s;

    phase_timer #(
        .CNT_W      (CNT_W),
        .T_MAIN_MIN (T_MAIN_MIN),
        .T_SIDE_MIN (T_SIDE_MIN),
        .T_SIDE_MAX (T_SIDE_MAX),
        .T_YEL      (T_YEL),
        .T_ALLRED   (T_ALLRED)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .clr_i         (state_d != state_q),
        .sat_main_i    (state_q == PH_MAIN_G),
        .main_min_o    (main_min_s),
        .side_min_o    (side_min_s),
        .side_max_o    (side_max_s),
        .yel_done_o    (yel_done_s),
        .allred_done_o (allred_done_s)
    );

`ifdef TRAFFIC_PED_EN
    logic ped_pend_q;
    logic ped_pend_d;
    logic walk_q;

    // Sticky pedestrian request, consumed when side green begins.
    always_comb begin
        ped_pend_d = ped_pend_q;
        if (state_d == PH_SIDE_G && state_q != PH_SIDE_G) begin
            ped_pend_d = 1'b0;
        end else if (ped_req) begin
            ped_pend_d = 1'b1;
        end else begin
            ped_pend_d = ped_pend_q;
        end
    end

    // Pedestrian registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
            walk_q     <= (state_d == PH_SIDE_G);
        end
    end

    assign req_s = traffic | ped_pend_q;
    assign walk  = walk_q;
`else
    assign req_s = traffic;
`endif

    // Phase sequencing; the max limit ends side green even with traffic present.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_MAIN_G:  if (main_min_s && req_s) state_d = PH_MAIN_Y;  else state_d = state_q;
            PH_MAIN_Y:  if (yel_done_s)          state_d = PH_ALLR_MS; else state_d = state_q;
            PH_ALLR_MS: if (allred_done_s)       state_d = PH_SIDE_G;  else state_d = state_q;
            PH_SIDE_G:  if (side_max_s || (side_min_s && !traffic))
                                                 state_d = PH_SIDE_Y;  else state_d = state_q;
            PH_SIDE_Y:  if (yel_done_s)          state_d = PH_ALLR_SM; else state_d = state_q;
            PH_ALLR_SM: if (allred_done_s)       state_d = PH_MAIN_G;  else state_d = state_q;
            default:                             state_d = PH_ALLR_SM;
        endcase
    end

    // State and light registers; lights are decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PH_ALLR_SM;
            light_q <= LT_ALLR;
        end else begin
            state_q <= state_d;
            light_q <= phase_lights(state_d);
        end
    end

    assign light = light_q;
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_ctrl_act.sv
// Scoreboard bench: stimulus pushes the expected light/phase for each cycle,
// a negedge monitor pops and compares.
module tb_traffic_ctrl_act;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       traffic;
    logic [5:0] light;
    logic [2:0] phase;
`ifdef TRAFFIC_PED_EN
    logic       ped_req;
    logic       walk;
`endif

    always #5 clk = ~clk;

    traffic_ctrl_act dut (
        .clk     (clk),
        .reset   (reset),
        .traffic (traffic),
`ifdef TRAFFIC_PED_EN
        .ped_req (ped_req),
        .walk    (walk),
`endif
        .light   (light),
        .phase   (phase)
    );

    typedef struct {
        logic [5:0] l;
        logic [2:0] p;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   seg_id = 0;

    task automatic push(input logic [5:0] l, input logic [2:0] p);
        exp_t e;
        e.l  = l;
        e.p  = p;
        e.id = seg_id;
        exp_q.push_back(e);
    endtask

    // n cycles expected in one phase; t is the traffic level sampled at the end of each.
    task automatic seg(input int n, input logic t, input logic [5:0] l, input logic [2:0] p);
        seg_id++;
        repeat (n) begin
            @(posedge clk);
            #1;
            push(l, p);
            traffic = t;
`ifdef TRAFFIC_PED_EN
            ped_req = 1'b0;
`endif
        end
    endtask

    task automatic set_reset(input logic r, input logic t);
        seg_id++;
        @(posedge clk);
        #1;
        reset   = r;
        traffic = t;
        push(LT_ALLR, PH_ALLR_SM);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (light !== e.l || phase !== e.p) begin
                bad++;
                $display("FAIL seg%0d t=%0t light=%b phase=%0d expected light=%b phase=%0d",
                         e.id, $time, light, phase, e.l, e.p);
            end
`ifdef TRAFFIC_PED_EN
            total++;
            if (walk !== (e.p == PH_SIDE_G)) begin
                bad++;
                $display("FAIL walk seg%0d t=%0t walk=%b expected %b",
                         e.id, $time, walk, (e.p == PH_SIDE_G));
            end
`endif
        end
    end

    initial begin
        reset   = 1'b0;
        traffic = 1'b0;
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b0;
`endif
        seg(5, 1'b0, LT_ALLR, PH_ALLR_SM);
        set_reset(1'b1, 1'b1);
        seg(1, 1'b1, LT_ALLR, PH_ALLR_SM);
        // Constant traffic: side green runs to its max limit.
        seg(10, 1'b1, LT_MAIN_G, PH_MAIN_G);
        seg(3,  1'b1, LT_MAIN_Y, PH_MAIN_Y);
        seg(2,  1'b1, LT_ALLR,   PH_ALLR_MS);
        seg(15, 1'b1, LT_SIDE_G, PH_SIDE_G);
        seg(3,  1'b1, LT_SIDE_Y, PH_SIDE_Y);
        seg(2,  1'b1, LT_ALLR,   PH_ALLR_SM);
        seg(10, 1'b1, LT_MAIN_G, PH_MAIN_G);
        seg(3,  1'b1, LT_MAIN_Y, PH_MAIN_Y);
        seg(2,  1'b1, LT_ALLR,   PH_ALLR_MS);
        // Early traffic drop: side green held to its minimum.
        seg(1,  1'b1, LT_SIDE_G, PH_SIDE_G);
        seg(4,  1'b0, LT_SIDE_G, PH_SIDE_G);
        seg(3,  1'b0, LT_SIDE_Y, PH_SIDE_Y);
        seg(2,  1'b0, LT_ALLR,   PH_ALLR_SM);
        // Main rests with no traffic, then reacts one cycle after the request.
        seg(29, 1'b0, LT_MAIN_G, PH_MAIN_G);
        seg(1,  1'b1, LT_MAIN_G, PH_MAIN_G);
        seg(3,  1'b1, LT_MAIN_Y, PH_MAIN_Y);
        seg(2,  1'b1, LT_ALLR,   PH_ALLR_MS);
        // Traffic drop during side-green cycle 8 ends it after cycle 8.
        seg(7,  1'b1, LT_SIDE_G, PH_SIDE_G);
        seg(1,  1'b0, LT_SIDE_G, PH_SIDE_G);
        seg(3,  1'b1, LT_SIDE_Y, PH_SIDE_Y);
        seg(2,  1'b1, LT_ALLR,   PH_ALLR_SM);
        seg(10, 1'b1, LT_MAIN_G, PH_MAIN_G);
        seg(3,  1'b1, LT_MAIN_Y, PH_MAIN_Y);
        seg(2,  1'b1, LT_ALLR,   PH_ALLR_MS);
        // Reset in side-green cycle 4 takes effect before the next edge.
        seg(3,  1'b1, LT_SIDE_G, PH_SIDE_G);
        set_reset(1'b0, 1'b0);
        seg(2,  1'b0, LT_ALLR,   PH_ALLR_SM);
        set_reset(1'b1, 1'b0);
        seg(1,  1'b0, LT_ALLR,   PH_ALLR_SM);
        seg(2,  1'b0, LT_MAIN_G, PH_MAIN_G);
        seg_id++;
        @(posedge clk);
        #1;
        push(LT_MAIN_G, PH_MAIN_G);
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b1;
`endif
        seg(7,  1'b0, LT_MAIN_G, PH_MAIN_G);
`ifdef TRAFFIC_PED_EN
        seg(3,  1'b0, LT_MAIN_Y, PH_MAIN_Y);
        seg(2,  1'b0, LT_ALLR,   PH_ALLR_MS);
        seg(5,  1'b0, LT_SIDE_G, PH_SIDE_G);
        seg(3,  1'b0, LT_SIDE_Y, PH_SIDE_Y);
        seg(2,  1'b0, LT_ALLR,   PH_ALLR_SM);
        seg(5,  1'b0, LT_MAIN_G, PH_MAIN_G);
`else
        seg(10, 1'b0, LT_MAIN_G, PH_MAIN_G);
`endif
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
